// File: rtl/sap_ctrl_if.sv
// Control bundle between the SAP sequencer (master) and the datapath (slave).
// Only the flags, run and the IR opcode flow into the sequencer; everything else flows out.
interface sap_ctrl_if #(
    parameter int OPCODE_W = 4
);
    // No valid/ready pair: run=1 lets the current T-state apply and advance at the next
    // posedge; run=0 holds the state and forces every control inactive.
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                carry;
    logic                zero;
    logic [5:0]          tstate;
    logic                clr_n;
    logic                cp;
    logic                ep;
    logic                lp;
    logic                lm_n;
    logic                ce_n;
    logic                li_n;
    logic                ei_n;
    logic                la_n;
    logic                ea;
    logic                su;
    logic                eu;
    logic                lb_n;
    logic                lo_n;
    logic                hlt;

    modport master (
        input  run, opcode, carry, zero,
        output tstate, clr_n, cp, ep, lp, lm_n, ce_n, li_n, ei_n,
               la_n, ea, su, eu, lb_n, lo_n, hlt
    );

    modport slave (
        output run, opcode, carry, zero,
        input  tstate, clr_n, cp, ep, lp, lm_n, ce_n, li_n, ei_n,
               la_n, ea, su, eu, lb_n, lo_n, hlt
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 style control sequencer: one-hot T1..T6 ring plus opcode decode into the control word.
// Optional JMP/JC/JZ support is compiled in when the macro JUMP_EN is defined.
module sap_control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    sap_ctrl_if.master bus
);

    typedef enum logic [NUM_T-1:0] {
        T1 = NUM_T'(1),
        T2 = NUM_T'(2),
        T3 = NUM_T'(4),
        T4 = NUM_T'(8),
        T5 = NUM_T'(16),
        T6 = NUM_T'(32)
    } tstate_e;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);
`ifdef JUMP_EN
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b0101);
`endif

    tstate_e state, state_next;
    logic    halted, halted_next;
    logic    active;

    // Internal active-high view of the control word; inversion happens at the port.
    logic cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        state_next  = state;
        halted_next = halted;
        if (bus.run && !halted) begin
            case (state)
                T1: state_next = T2;
                T2: state_next = T3;
                T3: state_next = T4;
                T4: begin
                    // HLT parks the ring on T4 until reset.
                    if (bus.opcode == OP_HLT) halted_next = 1'b1;
                    else                      state_next  = T5;
                end
                T5: state_next = T6;
                T6: state_next = T1;
                default: state_next = T1;
            endcase
        end
    end

    assign active = rst_n && bus.run && !halted;

    always_comb begin
        cp = 1'b0; ep = 1'b0; lp = 1'b0; lm = 1'b0; ce = 1'b0; li = 1'b0; ei = 1'b0;
        la = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lb = 1'b0; lo = 1'b0;
        if (active) begin
            case (state)
                T1: begin ep = 1'b1; lm = 1'b1; end
                T2: cp = 1'b1;
                T3: begin ce = 1'b1; li = 1'b1; end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
                        OP_OUT:                 begin ea = 1'b1; lo = 1'b1; end
`ifdef JUMP_EN
                        OP_JMP: begin ei = 1'b1; lp = 1'b1; end
                        OP_JC:  if (bus.carry) begin ei = 1'b1; lp = 1'b1; end
                        OP_JZ:  if (bus.zero)  begin ei = 1'b1; lp = 1'b1; end
`endif
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA:         begin ce = 1'b1; la = 1'b1; end
                        OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
                        default: ;
                    endcase
                end
                T6: begin
                    case (bus.opcode)
                        OP_ADD: begin eu = 1'b1; la = 1'b1; end
                        OP_SUB: begin eu = 1'b1; la = 1'b1; su = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifndef JUMP_EN
    logic unused_flags;
    assign unused_flags = bus.carry ^ bus.zero;
`endif

    assign bus.tstate = state;
    assign bus.clr_n  = rst_n;
    assign bus.hlt    = halted;
    assign bus.cp     = cp;
    assign bus.ep     = ep;
    assign bus.lp     = lp;
    assign bus.lm_n   = ~lm;
    assign bus.ce_n   = ~ce;
    assign bus.li_n   = ~li;
    assign bus.ei_n   = ~ei;
    assign bus.la_n   = ~la;
    assign bus.ea     = ea;
    assign bus.su     = su;
    assign bus.eu     = eu;
    assign bus.lb_n   = ~lb;
    assign bus.lo_n   = ~lo;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: ring order, per-opcode control words, pause, halt,
// reset, and a randomised stretch checking bus exclusivity and the ring position.
module tb_sap_control_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    sap_ctrl_if bus ();

    sap_control_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Packed control word: {cp,ep,lp,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n,hlt,clr_n}
    localparam logic [14:0] B_CP  = 15'd1 << 14;
    localparam logic [14:0] B_EP  = 15'd1 << 13;
    localparam logic [14:0] B_LP  = 15'd1 << 12;
    localparam logic [14:0] B_LM  = 15'd1 << 11;
    localparam logic [14:0] B_CE  = 15'd1 << 10;
    localparam logic [14:0] B_LI  = 15'd1 << 9;
    localparam logic [14:0] B_EI  = 15'd1 << 8;
    localparam logic [14:0] B_LA  = 15'd1 << 7;
    localparam logic [14:0] B_EA  = 15'd1 << 6;
    localparam logic [14:0] B_SU  = 15'd1 << 5;
    localparam logic [14:0] B_EU  = 15'd1 << 4;
    localparam logic [14:0] B_LB  = 15'd1 << 3;
    localparam logic [14:0] B_LO  = 15'd1 << 2;
    localparam logic [14:0] B_HLT = 15'd1 << 1;
    localparam logic [14:0] B_CLR = 15'd1 << 0;
    localparam logic [14:0] INACTIVE = B_LM | B_CE | B_LI | B_EI | B_LA | B_LB | B_LO | B_CLR;

`ifdef JUMP_EN
    localparam logic [14:0] JUMP_T4 = B_EI | B_LP;
`else
    localparam logic [14:0] JUMP_T4 = 15'd0;
`endif

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    function automatic logic [14:0] ctrl_obs();
        return {bus.cp, bus.ep, bus.lp, bus.lm_n, bus.ce_n, bus.li_n, bus.ei_n, bus.la_n,
                bus.ea, bus.su, bus.eu, bus.lb_n, bus.lo_n, bus.hlt, bus.clr_n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_t(input string tag, input logic [5:0] exp);
        vectors++;
        assert (bus.tstate === exp) else begin
            miscompares++;
            $error("FAIL %s: tstate=%b expected %b", tag, bus.tstate, exp);
        end
    endtask

    // 'asserted' lists the signals expected to be in their active level; all others inactive.
    task automatic chk_c(input string tag, input logic [14:0] asserted);
        logic [14:0] exp;
        logic [14:0] obs;
        exp = INACTIVE ^ asserted;
        obs = ctrl_obs();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: ctrl=%b expected %b", tag, obs, exp);
        end
    endtask

    // Expects to be entered at T1 with run=1; returns at T1 of the next instruction.
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic [14:0] e4, input logic [14:0] e5, input logic [14:0] e6);
        bus.opcode = op;
        #1;
        chk_t({tag, "_t1"}, T1); chk_c({tag, "_c1"}, B_EP | B_LM);
        step; chk_t({tag, "_t2"}, T2); chk_c({tag, "_c2"}, B_CP);
        step; chk_t({tag, "_t3"}, T3); chk_c({tag, "_c3"}, B_CE | B_LI);
        step; chk_t({tag, "_t4"}, T4); chk_c({tag, "_c4"}, e4);
        step; chk_t({tag, "_t5"}, T5); chk_c({tag, "_c5"}, e5);
        step; chk_t({tag, "_t6"}, T6); chk_c({tag, "_c6"}, e6);
        step; chk_t({tag, "_wrap"}, T1);
    endtask

    initial begin
        logic [5:0] exp_t;
        logic       run_now;
        int         drivers;

        rst_n      = 1'b0;
        bus.run    = 1'b0;
        bus.opcode = 4'b0000;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;

        // Reset: run raised during reset must not unmask the control word.
        step;
        bus.run = 1'b1;
        step;
        chk_t("rst_t", T1);
        chk_c("rst_c", B_CLR);

        rst_n = 1'b1;
        #1;
        chk_t("rel_t", T1);
        chk_c("rel_c", B_EP | B_LM);

        run_instr("add", 4'b0001, B_EI | B_LM, B_CE | B_LB, B_EU | B_LA);
        run_instr("sub", 4'b0010, B_EI | B_LM, B_CE | B_LB, B_EU | B_LA | B_SU);
        run_instr("lda", 4'b0000, B_EI | B_LM, B_CE | B_LA, 15'd0);
        run_instr("out", 4'b1110, B_EA | B_LO, 15'd0, 15'd0);
        run_instr("nop", 4'b0111, 15'd0, 15'd0, 15'd0);
        run_instr("jmp", 4'b0011, JUMP_T4, 15'd0, 15'd0);
        bus.carry = 1'b1;
        run_instr("jc1", 4'b0100, JUMP_T4, 15'd0, 15'd0);
        bus.carry = 1'b0;
        run_instr("jc0", 4'b0100, 15'd0, 15'd0, 15'd0);
        bus.zero = 1'b1;
        run_instr("jz1", 4'b0101, JUMP_T4, 15'd0, 15'd0);
        bus.zero = 1'b0;
        run_instr("jz0", 4'b0101, 15'd0, 15'd0, 15'd0);

        // Pause at T3 for five cycles, then resume.
        bus.opcode = 4'b0001;
        step; step;
        chk_t("pause_t3", T3);
        bus.run = 1'b0;
        #1;
        chk_c("pause_c", 15'd0);
        for (int i = 0; i < 5; i++) begin
            step;
            chk_t("pause_hold_t", T3);
            chk_c("pause_hold_c", 15'd0);
        end
        bus.run = 1'b1;
        #1;
        chk_c("resume_c", B_CE | B_LI);
        step;
        chk_t("resume_t4", T4);
        chk_c("resume_c4", B_EI | B_LM);
        step; step; step;
        chk_t("resume_wrap", T1);

        // Halt: ring parks on T4 and only reset clears it.
        bus.opcode = 4'b1111;
        step; step; step;
        chk_t("hlt_t4", T4);
        chk_c("hlt_pre_c", 15'd0);
        step;
        chk_t("hlt_set_t", T4);
        chk_c("hlt_set_c", B_HLT);
        for (int i = 0; i < 20; i++) begin
            bus.opcode = 4'($urandom_range(0, 15));
            step;
            chk_t("hlt_hold_t", T4);
            chk_c("hlt_hold_c", B_HLT);
        end
        rst_n = 1'b0;
        step;
        chk_t("hlt_rst_t", T1);
        chk_c("hlt_rst_c", B_CLR);
        rst_n = 1'b1;
        bus.opcode = 4'b0001;
        #1;
        chk_c("hlt_rel_c", B_EP | B_LM);

        // Reset in the middle of an instruction.
        step; step;
        chk_t("mid_t3", T3);
        rst_n = 1'b0;
        step;
        chk_t("mid_rst_t", T1);
        chk_c("mid_rst_c", B_CLR);
        rst_n = 1'b1;
        #1;
        chk_c("mid_rel_c", B_EP | B_LM);

        // Random opcodes (no HLT), random pauses and flags.
        exp_t = T1;
        for (int i = 0; i < 2000; i++) begin
            run_now    = ($urandom_range(0, 4) != 0);
            bus.run    = run_now;
            bus.opcode = 4'($urandom_range(0, 14));
            bus.carry  = 1'($urandom_range(0, 1));
            bus.zero   = 1'($urandom_range(0, 1));
            #1;
            drivers = $countones({bus.ep, ~bus.ce_n, ~bus.ei_n, bus.ea, bus.eu});
            vectors++;
            assert ((drivers <= 1) === 1'b1) else begin
                miscompares++;
                $error("FAIL bus_excl: drivers=%0d expected at most 1", drivers);
            end
            if (!run_now) chk_c("rand_pause_c", 15'd0);
            step;
            if (run_now) exp_t = {exp_t[4:0], exp_t[5]};
            chk_t("rand_t", exp_t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
